// File: rtl/dice_roll_engine.sv
// Unbiased multi-die roll engine: rejection-samples a stop/valid TRNG and streams 1-based results.
// Optional running sum of each request is built only when DICE_SUM_EN is defined.
module dice_roll_engine #(
  parameter int RAND_W   = 8,
  parameter int MAX_DICE = 8,
  parameter int CNT_W    = $clog2(MAX_DICE + 1),
  parameter int SUM_W    = 10
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [2:0]        i_die_sel,
  input  logic [CNT_W-1:0]  i_count,
  output logic              o_busy,
  output logic              o_stop,
  input  logic              i_rand_valid,
  input  logic [RAND_W-1:0] i_rand_data,
  output logic              o_roll_valid,
  output logic [6:0]        o_roll_data,
  output logic              o_roll_last,
  input  logic              i_roll_ready,
  output logic              o_err,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_sum_valid
);

  typedef enum logic [1:0] {IDLE, REQ, REARM, OUT} state_t;

  localparam int RANGE = 2 ** RAND_W;
  localparam int LIM_W = RAND_W + 1;

  // Largest multiple of the side count that fits in the sample range; samples
  // at or above it would bias the low faces, so they are thrown away.
  function automatic logic [LIM_W-1:0] limit_of(input logic [2:0] sel);
    case (sel)
      3'd0:    limit_of = LIM_W'((RANGE / 4) * 4);
      3'd1:    limit_of = LIM_W'((RANGE / 6) * 6);
      3'd2:    limit_of = LIM_W'((RANGE / 8) * 8);
      3'd3:    limit_of = LIM_W'((RANGE / 10) * 10);
      3'd4:    limit_of = LIM_W'((RANGE / 12) * 12);
      3'd5:    limit_of = LIM_W'((RANGE / 20) * 20);
      3'd6:    limit_of = LIM_W'((RANGE / 100) * 100);
      default: limit_of = '0;
    endcase
  endfunction

  // Constant divisors per branch keep each modulo a fixed-constant reduction.
  function automatic logic [6:0] roll_of(input logic [2:0] sel,
                                         input logic [RAND_W-1:0] data);
    int unsigned d;
    int unsigned r;
    d = 32'(data);
    case (sel)
      3'd0:    r = d % 4;
      3'd1:    r = d % 6;
      3'd2:    r = d % 8;
      3'd3:    r = d % 10;
      3'd4:    r = d % 12;
      3'd5:    r = d % 20;
      default: r = d % 100;
    endcase
    roll_of = 7'(r + 1);
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] remaining_q;
  logic [6:0]       roll_q;
  logic             err_q;

  logic start_ok, start_bad, take, drop, handshake, last_die;

  assign start_ok  = (state_q == IDLE) && i_start && (i_die_sel != 3'd7) &&
                     (i_count != '0) && (i_count <= CNT_W'(MAX_DICE));
  assign start_bad = (state_q == IDLE) && i_start && !start_ok;
  assign take      = (state_q == REQ) && i_rand_valid &&
                     ({1'b0, i_rand_data} < limit_of(sel_q));
  assign drop      = (state_q == REQ) && i_rand_valid && !take;
  assign handshake = (state_q == OUT) && i_roll_ready;
  assign last_die  = (remaining_q == CNT_W'(1));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    o_busy       = 1'b1;
    o_stop       = 1'b1;
    o_roll_valid = 1'b0;
    o_roll_last  = 1'b0;
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (start_ok) state_d = REQ;
      end
      REQ: begin
        o_stop = 1'b0;
        if (take)      state_d = OUT;
        else if (drop) state_d = REARM;
      end
      REARM: state_d = REQ;
      OUT: begin
        o_roll_valid = 1'b1;
        o_roll_last  = last_die;
        if (handshake) state_d = last_die ? IDLE : REARM;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      remaining_q <= '0;
      roll_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad;
      if (start_ok) begin
        sel_q       <= i_die_sel;
        remaining_q <= i_count;
      end
      if (take)      roll_q      <= roll_of(sel_q, i_rand_data);
      if (handshake) remaining_q <= remaining_q - CNT_W'(1);
    end
  end

  assign o_roll_data = roll_q;
  assign o_err       = err_q;

`ifdef DICE_SUM_EN
  logic [SUM_W-1:0] sum_q;
  logic             sum_valid_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= handshake && last_die;
      if (start_ok)       sum_q <= '0;
      else if (handshake) sum_q <= sum_q + SUM_W'(roll_q);
    end
  end

  assign o_sum       = sum_q;
  assign o_sum_valid = sum_valid_q;
`else
  assign o_sum       = '0;
  assign o_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed bench for dice_roll_engine; expected sums follow DICE_SUM_EN when it is defined.
module tb_dice_roll_engine;

  localparam int RAND_W = 8;
  localparam int CNT_W  = 4;
  localparam int SUM_W  = 10;
`ifdef DICE_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        die_sel = '0;
  logic [CNT_W-1:0]  count = '0;
  logic              busy, stop;
  logic              rand_valid = 1'b0;
  logic [RAND_W-1:0] rand_data = '0;
  logic              roll_valid;
  logic [6:0]        roll_data;
  logic              roll_last;
  logic              roll_ready = 1'b0;
  logic              err;
  logic [SUM_W-1:0]  sum;
  logic              sum_valid;

  int total  = 0;
  int passed = 0;

  dice_roll_engine dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_die_sel(die_sel),
    .i_count(count), .o_busy(busy), .o_stop(stop), .i_rand_valid(rand_valid),
    .i_rand_data(rand_data), .o_roll_valid(roll_valid), .o_roll_data(roll_data),
    .o_roll_last(roll_last), .i_roll_ready(roll_ready), .o_err(err),
    .o_sum(sum), .o_sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [2:0] sel, input logic [CNT_W-1:0] n);
    start = 1'b1; die_sel = sel; count = n;
    step();
    start = 1'b0;
  endtask

  // Presents one sample, waits for the engine to be in REQ, and lets it be taken.
  task automatic feed(input logic [RAND_W-1:0] d);
    bit ok = 1'b0;
    rand_valid = 1'b1; rand_data = d;
    for (int i = 0; i < 10; i++) begin
      if (stop === 1'b0) begin ok = 1'b1; break; end
      step();
    end
    total++; if (!ok) $display("FAIL feed_timeout: sample %0d never requested", d); else passed++;
    step();
    rand_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    total++; if (busy !== 1'b0) $display("FAIL por_busy: got %b want 0", busy); else passed++;
    total++; if (stop !== 1'b1) $display("FAIL por_stop: got %b want 1", stop); else passed++;
    reset_n = 1'b1;
    step();
    start_req(3'd1, 4'd2);
    total++; if (stop !== 1'b0) $display("FAIL req_stop: got %b want 0", stop); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL req_busy: got %b want 1", busy); else passed++;
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (stop !== 1'b1) $display("FAIL rst_stop: got %b want 1", stop); else passed++;
    total++; if (roll_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", roll_valid); else passed++;
    total++; if (roll_data !== 7'd0) $display("FAIL rst_data: got %0d want 0", roll_data); else passed++;
    total++; if (roll_last !== 1'b0) $display("FAIL rst_last: got %b want 0", roll_last); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passed++;
    total++; if (sum !== 10'd0) $display("FAIL rst_sum: got %0d want 0", sum); else passed++;
    total++; if (sum_valid !== 1'b0) $display("FAIL rst_sum_valid: got %b want 0", sum_valid); else passed++;
    // Fresh request after reset: d4, sample 5 -> 2.
    start_req(3'd0, 4'd1);
    feed(8'd5);
    total++; if (roll_data !== 7'd2) $display("FAIL post_rst_data: got %0d want 2", roll_data); else passed++;
    total++; if (roll_last !== 1'b1) $display("FAIL post_rst_last: got %b want 1", roll_last); else passed++;
    roll_ready = 1'b1;
    step();
    roll_ready = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", busy); else passed++;
    total++; if (sum !== (SUM_EN ? 10'd2 : 10'd0)) $display("FAIL post_rst_sum: got %0d want %0d", sum, SUM_EN ? 2 : 0); else passed++;
  endtask

  task automatic test_d6_reject();
    start_req(3'd1, 4'd1);
    rand_valid = 1'b1; rand_data = 8'd252;
    step();
    total++; if (stop !== 1'b1) $display("FAIL d6_rearm_stop: got %b want 1", stop); else passed++;
    total++; if (roll_valid !== 1'b0) $display("FAIL d6_rearm_valid: got %b want 0", roll_valid); else passed++;
    rand_data = 8'd251;
    step();
    total++; if (stop !== 1'b0) $display("FAIL d6_req_stop: got %b want 0", stop); else passed++;
    step();
    rand_valid = 1'b0;
    total++; if (roll_valid !== 1'b1) $display("FAIL d6_valid: got %b want 1", roll_valid); else passed++;
    total++; if (roll_data !== 7'd6) $display("FAIL d6_data: got %0d want 6", roll_data); else passed++;
    total++; if (roll_last !== 1'b1) $display("FAIL d6_last: got %b want 1", roll_last); else passed++;
    roll_ready = 1'b1;
    step();
    roll_ready = 1'b0;
    total++; if (sum_valid !== SUM_EN) $display("FAIL d6_sum_valid: got %b want %b", sum_valid, SUM_EN); else passed++;
    total++; if (sum !== (SUM_EN ? 10'd6 : 10'd0)) $display("FAIL d6_sum: got %0d want %0d", sum, SUM_EN ? 6 : 0); else passed++;
    step();
    total++; if (sum_valid !== 1'b0) $display("FAIL d6_sum_pulse: got %b want 0", sum_valid); else passed++;
    total++; if (sum !== (SUM_EN ? 10'd6 : 10'd0)) $display("FAIL d6_sum_hold: got %0d want %0d", sum, SUM_EN ? 6 : 0); else passed++;
  endtask

  task automatic test_d100_stream();
    roll_ready = 1'b1;
    start_req(3'd6, 4'd3);
    feed(8'd199);
    total++; if (roll_data !== 7'd100) $display("FAIL d100_r1: got %0d want 100", roll_data); else passed++;
    total++; if (roll_last !== 1'b0) $display("FAIL d100_r1_last: got %b want 0", roll_last); else passed++;
    step();
    feed(8'd0);
    total++; if (roll_data !== 7'd1) $display("FAIL d100_r2: got %0d want 1", roll_data); else passed++;
    step();
    feed(8'd200);
    total++; if (roll_valid !== 1'b0) $display("FAIL d100_rej_valid: got %b want 0", roll_valid); else passed++;
    total++; if (stop !== 1'b1) $display("FAIL d100_rej_stop: got %b want 1", stop); else passed++;
    feed(8'd57);
    total++; if (roll_data !== 7'd58) $display("FAIL d100_r3: got %0d want 58", roll_data); else passed++;
    total++; if (roll_last !== 1'b1) $display("FAIL d100_r3_last: got %b want 1", roll_last); else passed++;
    total++; if (sum_valid !== 1'b0) $display("FAIL d100_early_sum: got %b want 0", sum_valid); else passed++;
    step();
    roll_ready = 1'b0;
    total++; if (sum_valid !== SUM_EN) $display("FAIL d100_sum_valid: got %b want %b", sum_valid, SUM_EN); else passed++;
    total++; if (sum !== (SUM_EN ? 10'd159 : 10'd0)) $display("FAIL d100_sum: got %0d want %0d", sum, SUM_EN ? 159 : 0); else passed++;
  endtask

  task automatic test_d20_backpressure();
    start_req(3'd5, 4'd2);
    feed(8'd17);
    for (int i = 0; i < 5; i++) begin
      rand_valid = 1'b1; rand_data = 8'd3;
      step();
      total++; if (roll_valid !== 1'b1) $display("FAIL d20_hold_valid%0d: got %b want 1", i, roll_valid); else passed++;
      total++; if (roll_data !== 7'd18) $display("FAIL d20_hold_data%0d: got %0d want 18", i, roll_data); else passed++;
    end
    rand_valid = 1'b0;
    roll_ready = 1'b1;
    step();
    roll_ready = 1'b0;
    total++; if (stop !== 1'b1) $display("FAIL d20_rearm: got %b want 1", stop); else passed++;
    feed(8'd39);
    total++; if (roll_data !== 7'd20) $display("FAIL d20_r2: got %0d want 20", roll_data); else passed++;
    total++; if (roll_last !== 1'b1) $display("FAIL d20_r2_last: got %b want 1", roll_last); else passed++;
    roll_ready = 1'b1;
    step();
    roll_ready = 1'b0;
    total++; if (sum !== (SUM_EN ? 10'd38 : 10'd0)) $display("FAIL d20_sum: got %0d want %0d", sum, SUM_EN ? 38 : 0); else passed++;
  endtask

  task automatic test_invalid();
    logic [2:0]       sels [3] = '{3'd7, 3'd0, 3'd0};
    logic [CNT_W-1:0] cnts [3] = '{4'd1, 4'd0, 4'd9};
    for (int i = 0; i < 3; i++) begin
      start_req(sels[i], cnts[i]);
      total++; if (err !== 1'b1) $display("FAIL inv%0d_err: got %b want 1", i, err); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL inv%0d_busy: got %b want 0", i, busy); else passed++;
      total++; if (stop !== 1'b1) $display("FAIL inv%0d_stop: got %b want 1", i, stop); else passed++;
      step();
      total++; if (err !== 1'b0) $display("FAIL inv%0d_err_pulse: got %b want 0", i, err); else passed++;
    end
    total++; if (sum !== (SUM_EN ? 10'd38 : 10'd0)) $display("FAIL inv_sum_hold: got %0d want %0d", sum, SUM_EN ? 38 : 0); else passed++;
  endtask

  task automatic test_start_while_busy();
    roll_ready = 1'b1;
    start_req(3'd0, 4'd2);
    start = 1'b1; die_sel = 3'd6; count = 4'd1;
    feed(8'd6);
    total++; if (roll_data !== 7'd3) $display("FAIL busy_r1: got %0d want 3", roll_data); else passed++;
    total++; if (roll_last !== 1'b0) $display("FAIL busy_r1_last: got %b want 0", roll_last); else passed++;
    total++; if (err !== 1'b0) $display("FAIL busy_err: got %b want 0", err); else passed++;
    step();
    feed(8'd255);
    start = 1'b0;
    total++; if (roll_data !== 7'd4) $display("FAIL busy_r2: got %0d want 4", roll_data); else passed++;
    total++; if (roll_last !== 1'b1) $display("FAIL busy_r2_last: got %b want 1", roll_last); else passed++;
    step();
    roll_ready = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL busy_done: got %b want 0", busy); else passed++;
    total++; if (sum !== (SUM_EN ? 10'd7 : 10'd0)) $display("FAIL busy_sum: got %0d want %0d", sum, SUM_EN ? 7 : 0); else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_d6_reject();
    test_d100_stream();
    test_d20_backpressure();
    test_invalid();
    test_start_while_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/dice_roll_engine.md
# dice_roll_engine

Parametrised, unbiased multi-die roll engine between the TRNG (ring-oscillator entropy source with stop/valid handshake) and the display/UART formatter. On a start request it rolls 1..MAX_DICE dice of one selected type, drives the TRNG stop line, discards out-of-range samples (rejection sampling, no modulo bias), and streams 1-based results over a valid/ready interface with an optional running sum.

## Interface
- RAND_W, 8, width of TRNG sample; must be >= 7
- MAX_DICE, 8, maximum dice per request
- CNT_W, $clog2(MAX_DICE+1), width of i_count (derived)
- SUM_W, 10, width of o_sum; must hold MAX_DICE*100
- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_start  in  1  roll request pulse; sampled only in IDLE
- i_die_sel  in  3  0:d4 1:d6 2:d8 3:d10 4:d12 5:d20 6:d100 7:invalid
- i_count  in  CNT_W  dice to roll, 1..MAX_DICE
- o_busy  out  1  high in every state except IDLE
- o_stop  out  1  TRNG stop; 1 = oscillator halted/reset, 0 = run
- i_rand_valid  in  1  TRNG sample valid
- i_rand_data  in  RAND_W  TRNG sample
- o_roll_valid  out  1  roll result valid
- o_roll_data  out  7  roll result, 1..sides
- o_roll_last  out  1  qualifies final die of request
- i_roll_ready  in  1  downstream accepts result
- o_err  out  1  one-cycle pulse: request rejected
- o_sum  out  SUM_W  sum of request (DICE_SUM_EN only)
- o_sum_valid  out  1  one-cycle pulse with final sum (DICE_SUM_EN only)

## Operation
- States: IDLE, REQ, REARM, OUT.
- IDLE: o_stop=1. i_start with i_die_sel!=7 and 1<=i_count<=MAX_DICE: latch sides, limit, count; clear sum; -> REQ. Otherwise with i_start: o_err pulse, stay IDLE.
- REQ: o_stop=0. i_rand_valid with i_rand_data < LIMIT: result = (i_rand_data % sides) + 1 registered to o_roll_data; -> OUT. i_rand_valid with i_rand_data >= LIMIT: discard, -> REARM.
- LIMIT per die = (2^RAND_W / sides) * sides, elaboration-time constants. RAND_W=8: d4 256, d6 252, d8 256, d10 250, d12 252, d20 240, d100 200.
- REARM: o_stop=1 for exactly one cycle, -> REQ (fresh sample).
- OUT: o_stop=1, o_roll_valid=1; o_roll_data/o_roll_last stable until handshake. On i_roll_valid&&i_roll_ready: add result to sum; remaining-1; if that was the last die -> IDLE (o_sum_valid pulse), else -> REARM.
- o_roll_last=1 when remaining==1.
- i_start outside IDLE ignored; i_rand_valid outside REQ ignored; i_die_sel/i_count changes after acceptance ignored.
- Reset values: o_busy=0, o_stop=1, o_roll_valid=0, o_roll_data=0, o_roll_last=0, o_err=0, o_sum=0, o_sum_valid=0, state IDLE. Reset mid-request aborts it; no partial sum reported.

## Timing
- i_start accepted at edge T; o_busy=1, o_stop=0 from T+1.
- Sample accepted at edge N in REQ; o_roll_valid=1 from N+1 (1-cycle latency).
- Reject at N: o_stop=1 during N+1, o_stop=0 from N+2.
- Handshake at edge H (not last): REARM at H+1, REQ at H+2.
- Handshake of last die at H: o_busy=0 and o_sum_valid=1 during H+1; o_sum holds final value until next accepted start.
- o_err high exactly one cycle after the rejected i_start edge.
- Max throughput: one die per 3 cycles with ready held high and immediate valid samples.

## Configuration
- DICE_SUM_EN defined: sum accumulator (SUM_W bits, no overflow by parameter rule), o_sum and o_sum_valid as above.
- DICE_SUM_EN undefined: accumulator removed; o_sum tied 0, o_sum_valid tied 0; all other behaviour identical.

## Test plan
- Reset: hold i_reset_n=0 mid-REQ 2 cycles -> all outputs at reset values, state IDLE, next start behaves normally.
- d6, count 1, samples 252 then 251 -> 252 rejected (o_stop 1 for one cycle), o_roll_data=6, o_roll_last=1, o_sum=6.
- d100, count 3, samples 199, 0, 200, 57, ready always 1 -> rolls 100, 1, 58 (200 rejected); o_sum=159 pulsed after third handshake.
- d20, count 2, i_roll_ready low 5 cycles on first result -> o_roll_valid/o_roll_data=18 (sample 17) held stable; i_rand_valid during OUT ignored.
- Invalid requests: i_die_sel=7, then i_count=0, then i_count=9 -> o_err pulse each, o_busy stays 0, o_stop stays 1.
- i_start asserted while busy -> ignored; in-flight request completes with original die and count.
